program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, memory word width; equals the CPU instruction width (opcode + operand).
REQ-002 Parameter ADDR_WIDTH, default 5, memory address width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request to begin a load; sampled only in IDLE.
REQ-006 last_addr  input  ADDR_WIDTH  final address to write; sampled with start.
REQ-007 abort  input  1  terminate the load in progress.
REQ-008 s_valid  input  1  source word valid.
REQ-009 s_data  input  DATA_WIDTH  source word (program image, address 0 upward).
REQ-010 s_ready  output  1  loader accepts a word this cycle.
REQ-011 mem_wr  output  1  memory write strobe, one cycle per word.
REQ-012 mem_addr  output  ADDR_WIDTH  write address.
REQ-013 mem_data  output  DATA_WIDTH  write data.
REQ-014 cpu_halt  output  1  holds CPU/controller stalled while loading.
REQ-015 done  output  1  one-cycle pulse: load completed.
REQ-016 err  output  1  sticky: last load was aborted.
REQ-017 checksum  output  DATA_WIDTH  modulo-2^DATA_WIDTH sum of the words written.

Function
REQ-018 The FSM SHALL have states IDLE, WAIT, WRITE and DONE; all outputs are registered or decoded from state only.
REQ-019 In IDLE with start=1: capture last_addr, clear write pointer, checksum and err, and go to WAIT.
REQ-020 In WAIT, s_ready SHALL be 1; in all other states s_ready SHALL be 0.
REQ-021 A word is accepted at an edge where s_valid=1 and s_ready=1: mem_data<=s_data, mem_addr<=pointer, checksum<=checksum+s_data (carry discarded), and the state goes to WRITE.
REQ-022 In WAIT with s_valid=0, the loader SHALL hold all state; there is no timeout.
REQ-023 In WRITE, mem_wr SHALL be 1 for exactly that one cycle; mem_addr and mem_data are stable for the whole cycle.
REQ-024 Leaving WRITE: if pointer==last_addr, go to DONE; otherwise increment pointer and return to WAIT; the pointer never wraps.
REQ-025 Throughput SHALL be one word per 2 cycles maximum.
REQ-026 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-027 cpu_halt SHALL be 1 in WAIT, WRITE and DONE, and 0 in IDLE.
REQ-028 last_addr=0 SHALL load exactly one word; last_addr=2^ADDR_WIDTH-1 SHALL load the full memory.
REQ-029 start outside IDLE SHALL be ignored; last_addr changes after capture SHALL be ignored.
REQ-030 abort in WAIT or WRITE SHALL go to IDLE next edge with err<=1, no done pulse, and no further mem_wr.
REQ-031 abort takes priority over acceptance in the same cycle; a write strobe already asserted in WRITE completes that cycle.
REQ-032 abort in IDLE or DONE SHALL be ignored.
REQ-033 checksum and err SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-034 rst=1 at an edge SHALL force IDLE from any state, mid-load included.
REQ-035 On reset, all outputs SHALL be 0 and the pointer and captured last_addr SHALL be 0.
REQ-036 rst SHALL take priority over start and abort.
REQ-037 Memory contents already written SHALL NOT be undone by reset.

Verification
REQ-038 Basic load: start, last_addr=3, words 0x21,0x42,0x63,0x84 with s_valid always 1 -> mem_wr pulses at addrs 0..3 with those data; one done pulse; checksum=0x4A; cpu_halt high from the cycle after start through DONE.
REQ-039 Source stalls: as REQ-038 with s_valid low 3 cycles between words -> same writes and checksum; s_ready stays 1 throughout each stall; no extra mem_wr.
REQ-040 Edge lengths: last_addr=0 with word 0xFF -> one write at addr 0, checksum=0xFF; last_addr=31 with 32 words of 0x10 -> 32 writes at addrs 0..31, checksum=0x00, no wrap.
REQ-041 Abort: abort in the cycle the 3rd word is offered -> that word is not written; state IDLE; err=1; no done; a following start clears err.
REQ-042 Reset mid-load: rst during WRITE of addr 2 -> next cycle all outputs 0 and state IDLE; a new start reloads from addr 0.
REQ-043 Start while busy: pulse start during WAIT with a new last_addr -> the load continues to the original last_addr.

Source files
------------

// File: rtl/program_loader_if.sv
// program_loader_if -- handshake and memory-write bundle for program_loader.
//
// Groups everything except clk/rst:
//   start, last_addr, abort          load control (from host/sequencer)
//   s_valid, s_data / s_ready        source word stream (valid/ready)
//   mem_wr, mem_addr, mem_data       program memory write port
//   cpu_halt, done, err, checksum    status back to host / CPU
//
// modport master: the side that requests loads and supplies words.
// modport slave : the loader itself.
interface program_loader_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5
);

  logic                  start;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic                  abort;
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  cpu_halt;
  logic                  done;
  logic                  err;
  logic [DATA_WIDTH-1:0] checksum;

  modport master (
    output start, last_addr, abort, s_valid, s_data,
    input  s_ready, mem_wr, mem_addr, mem_data, cpu_halt, done, err, checksum
  );

  modport slave (
    input  start, last_addr, abort, s_valid, s_data,
    output s_ready, mem_wr, mem_addr, mem_data, cpu_halt, done, err, checksum
  );

endinterface

// File: rtl/program_loader.sv
// program_loader -- copies a program image from a valid/ready word stream into
// program memory (address 0 upward) while holding the CPU halted.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (forces IDLE, clears all outputs)
//   bus   program_loader_if.slave:
//           in : start, last_addr (captured with start), abort, s_valid, s_data
//           out: s_ready (WAIT only), mem_wr/mem_addr/mem_data (one strobe per
//                word), cpu_halt (any non-IDLE state), done (1-cycle pulse),
//                err (sticky: last load aborted), checksum (mod 2^DATA_WIDTH
//                sum of words written)
//
// Every accepted word costs a WAIT cycle and a WRITE cycle, so the stream rate
// is at most one word per two clocks. Outputs are all flops; the state-decoded
// ones are computed from the next state so they line up with the state flop.
module program_loader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic            clk,
  input  logic            rst,
  program_loader_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
  logic                  err_q, err_d;
  logic                  s_ready_q, s_ready_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  cpu_halt_q, cpu_halt_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    last_d     = last_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    checksum_d = checksum_q;
    err_d      = err_q;

    unique case (state_q)
      S_IDLE: begin
        // abort is meaningless here; checksum/err keep the last load's result
        if (bus.start) begin
          last_d     = bus.last_addr;
          ptr_d      = '0;
          checksum_d = '0;
          err_d      = 1'b0;
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        // abort wins over a word offered in the same cycle
        if (bus.abort) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (bus.s_valid && s_ready_q) begin
          mem_addr_d = ptr_q;
          mem_data_d = bus.s_data;
          checksum_d = checksum_q + bus.s_data;
          state_d    = S_WRITE;
        end
      end

      S_WRITE: begin
        // the strobe for this cycle is already out; abort only stops what follows
        if (bus.abort) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (ptr_q == last_q) begin
          state_d = S_DONE;
        end else begin
          ptr_d   = ptr_q + ADDR_WIDTH'(1);
          state_d = S_WAIT;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    s_ready_d  = (state_d == S_WAIT);
    mem_wr_d   = (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
    cpu_halt_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      last_q     <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      checksum_q <= '0;
      err_q      <= 1'b0;
      s_ready_q  <= 1'b0;
      mem_wr_q   <= 1'b0;
      cpu_halt_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      last_q     <= last_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      checksum_q <= checksum_d;
      err_q      <= err_d;
      s_ready_q  <= s_ready_d;
      mem_wr_q   <= mem_wr_d;
      cpu_halt_q <= cpu_halt_d;
      done_q     <= done_d;
    end
  end

  assign bus.s_ready  = s_ready_q;
  assign bus.mem_wr   = mem_wr_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign bus.cpu_halt = cpu_halt_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.checksum = checksum_q;

  // Accepting and writing are mutually exclusive phases of a word.
  a_ready_wr_excl: assert property (@(posedge clk) disable iff (rst)
    !(s_ready_q && mem_wr_q));

  a_done_pulse: assert property (@(posedge clk) disable iff (rst)
    done_q |=> !done_q);

  a_wr_pulse: assert property (@(posedge clk) disable iff (rst)
    mem_wr_q |=> !mem_wr_q);

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int DW = 8;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  program_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  program_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] src [0:31];

  typedef struct {
    int la;
    int mode;       // 0: word i = 0x21*(i+1), 1: every word = val
    int val;
    int stall;      // fixed source stall cycles before each word
    int abort_idx;
    int abort_ph;   // -1 none, 0 with word offer, 1 during WRITE, 2 during DONE
    int exp_writes;
    int exp_ck;
    int exp_err;
    int exp_done;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input int i);
    return (i >= 0 && i < 32) ? src[i] : '0;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"},  bus.s_ready,  0);
    chk({tag, "_mem_wr"},   bus.mem_wr,   0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_data"}, bus.mem_data, 0);
    chk({tag, "_cpu_halt"}, bus.cpu_halt, 0);
    chk({tag, "_done"},     bus.done,     0);
    chk({tag, "_err"},      bus.err,      0);
    chk({tag, "_checksum"}, bus.checksum, 0);
  endtask

  // Drives one load, checks it against the load-level model, returns counts.
  task automatic run_load(input int la, input int stall_max, input bit rnd_stall,
                          input int abort_idx, input int abort_ph,
                          output int n_wr, output int done_cnt);
    int n, widx, stall_left, s_tot, done_t, budget;
    int exp_n, exp_ck, exp_err, exp_done;
    bit ended, stall_chk, prev_wr, pace_ok;
    n = la + 1; widx = 0; s_tot = 0; n_wr = 0; done_cnt = 0; done_t = -1;
    ended = 0; stall_chk = 0; prev_wr = 0; pace_ok = 1;
    budget = 6 * n + 20;
    stall_left = rnd_stall ? int'($urandom_range(stall_max, 0)) : stall_max;

    @(negedge clk);
    bus.start = 1'b1; bus.last_addr = AW'(la); bus.abort = 1'b0; bus.s_valid = 1'b0;
    for (int t = 1; t <= budget; t++) begin
      @(negedge clk);
      if (!bus.cpu_halt) begin ended = 1; break; end
      if (t == 1) begin
        chk("start_clears_ck", bus.checksum, 0);
        chk("start_clears_err", bus.err, 0);
      end
      if (bus.mem_wr) begin
        chk("wr_addr", bus.mem_addr, n_wr);
        chk("wr_data", bus.mem_data, word(n_wr));
        if (prev_wr) pace_ok = 0;
        n_wr++;
      end
      prev_wr = bus.mem_wr;
      if (bus.done) begin done_cnt++; done_t = t; end
      if (stall_chk) chk("stall_ready", bus.s_ready, 1);
      stall_chk = 0;

      bus.abort     = 1'b0;
      bus.start     = (t == 1) || ($urandom_range(3, 0) == 0);
      bus.last_addr = AW'($urandom);
      if (bus.s_ready) begin
        if (abort_ph == 0 && widx == abort_idx && stall_left == 0) begin
          bus.s_valid = 1'b1; bus.s_data = word(widx); bus.abort = 1'b1;
        end else if (stall_left > 0) begin
          bus.s_valid = 1'b0; bus.s_data = DW'($urandom);
          stall_left--; s_tot++; stall_chk = 1;
        end else begin
          bus.s_valid = 1'b1; bus.s_data = word(widx); widx++;
          stall_left = rnd_stall ? int'($urandom_range(stall_max, 0)) : stall_max;
        end
      end else begin
        bus.s_valid = (widx < n);
        bus.s_data  = (widx < n) ? word(widx) : DW'($urandom);
        if (abort_ph == 1 && bus.mem_wr && widx == abort_idx + 1) bus.abort = 1'b1;
        if (abort_ph == 2 && bus.done) bus.abort = 1'b1;
      end
    end
    bus.start = 1'b0; bus.abort = 1'b0; bus.s_valid = 1'b0;

    if (abort_ph == 0 && abort_idx < n) begin
      exp_n = abort_idx; exp_err = 1; exp_done = 0;
    end else if (abort_ph == 1 && abort_idx < n) begin
      exp_n = abort_idx + 1; exp_err = 1; exp_done = 0;
    end else begin
      exp_n = n; exp_err = 0; exp_done = 1;
    end
    exp_ck = 0;
    for (int i = 0; i < exp_n; i++) exp_ck = (exp_ck + int'(src[i])) % 256;

    chk("load_terminates", ended, 1);
    chk("n_writes", n_wr, exp_n);
    chk("checksum", bus.checksum, exp_ck);
    chk("err", bus.err, exp_err);
    chk("done_pulses", done_cnt, exp_done);
    if (exp_done == 1) chk("done_cycle", done_t, 2 * n + 1 + s_tot);
    chk("max_one_word_per_2cyc", pace_ok, 1);
    chk("idle_s_ready", bus.s_ready, 0);

    // Idle gap: abort and stray source traffic must not disturb the result.
    for (int g = 0; g < 2; g++) begin
      bus.abort   = 1'b1;
      bus.s_valid = 1'(($urandom_range(1, 0)));
      bus.s_data  = DW'($urandom);
      @(negedge clk);
    end
    bus.abort = 1'b0; bus.s_valid = 1'b0;
    chk("idle_ck_hold", bus.checksum, exp_ck);
    chk("idle_err_hold", bus.err, exp_err);
    chk("idle_halt", bus.cpu_halt, 0);
    chk("idle_no_wr", bus.mem_wr, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_wr, done_cnt, idx, la, ph, aidx;
    bit found;

    rst = 1'b1;
    bus.start = 1'b0; bus.last_addr = '0; bus.abort = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0;

    tbl[0] = '{3,  0, 0,    0, -1, -1, 4,  'h4A, 0, 1};  // basic load
    tbl[1] = '{3,  0, 0,    3, -1, -1, 4,  'h4A, 0, 1};  // 3-cycle source stalls
    tbl[2] = '{0,  1, 'hFF, 0, -1, -1, 1,  'hFF, 0, 1};  // single word
    tbl[3] = '{31, 1, 'h10, 0, -1, -1, 32, 'h00, 0, 1};  // full memory
    tbl[4] = '{3,  0, 0,    0, 2,  0,  2,  'h63, 1, 0};  // abort as 3rd word offered
    tbl[5] = '{1,  0, 0,    1, -1, -1, 2,  'h63, 0, 1};  // next start clears err
    tbl[6] = '{3,  0, 0,    0, 1,  1,  2,  'h63, 1, 0};  // abort during WRITE of addr 1
    tbl[7] = '{2,  0, 0,    0, 0,  2,  3,  'hC6, 0, 1};  // abort in DONE ignored

    // Reset state, and reset beating start.
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    bus.start = 1'b1; bus.last_addr = 5'd7;
    @(negedge clk);
    chk("rst_over_start_halt", bus.cpu_halt, 0);
    chk("rst_over_start_ready", bus.s_ready, 0);
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[k]) begin
      for (int i = 0; i < 32; i++)
        src[i] = (tbl[k].mode == 0) ? DW'(33 * (i + 1)) : DW'(tbl[k].val);
      run_load(tbl[k].la, tbl[k].stall, 1'b0, tbl[k].abort_idx, tbl[k].abort_ph,
               n_wr, done_cnt);
      chk($sformatf("tbl%0d_writes", k), n_wr, tbl[k].exp_writes);
      chk($sformatf("tbl%0d_checksum", k), bus.checksum, tbl[k].exp_ck);
      chk($sformatf("tbl%0d_err", k), bus.err, tbl[k].exp_err);
      chk($sformatf("tbl%0d_done", k), done_cnt, tbl[k].exp_done);
    end

    // Reset during the WRITE cycle of address 2.
    for (int i = 0; i < 32; i++) src[i] = DW'(8'h50 + i);
    @(negedge clk);
    bus.start = 1'b1; bus.last_addr = 5'd5; bus.s_valid = 1'b1; bus.s_data = '0;
    idx = 0; found = 0;
    for (int t = 0; t < 40 && !found; t++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.mem_wr && bus.mem_addr == 5'd2) begin
        found = 1; rst = 1'b1;
      end else if (bus.s_ready) begin
        bus.s_data = word(idx); idx++;
      end
    end
    chk("reach_write_addr2", found, 1);
    @(negedge clk);
    chk_all_zero("rst_midload");
    rst = 1'b0; bus.s_valid = 1'b0;
    run_load(2, 0, 1'b0, -1, -1, n_wr, done_cnt);
    chk("reload_writes", n_wr, 3);

    // Randomised loads against the load-level model.
    for (int r = 0; r < 24; r++) begin
      la = ($urandom_range(3, 0) == 0) ? int'($urandom_range(31, 0)) : int'($urandom_range(7, 0));
      for (int i = 0; i < 32; i++) src[i] = DW'($urandom);
      case ($urandom_range(9, 0))
        0, 1:    ph = 0;
        2, 3:    ph = 1;
        4:       ph = 2;
        default: ph = -1;
      endcase
      aidx = int'($urandom_range(la, 0));
      run_load(la, 2, 1'b1, aidx, ph, n_wr, done_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
